// File: rtl/link_pkg.sv
// Constants and types shared by the leaf endpoint and the root-hub router.
package link_pkg;

    localparam int unsigned LINK_CHANNEL_WIDTH = 64;
    localparam int unsigned LINK_DEST_WIDTH    = 8;
    localparam int unsigned LINK_TYPE_WIDTH    = 8;

    localparam logic [LINK_TYPE_WIDTH-1:0] MSG_PING = 8'h01;
    localparam logic [LINK_TYPE_WIDTH-1:0] MSG_PONG = 8'h02;

    // Wide enough to slice down to any destination width.
    localparam logic [63:0] BROADCAST = '1;

    typedef enum logic [1:0] {
        RX_DELIVER,
        RX_PING,
        RX_DROP
    } rx_class_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_CORE,
        TX_PONG
    } tx_state_e;

endpackage

// File: rtl/leaf_hub_link_if.sv
// Link FIFO and core-side handshake bundle of the leaf endpoint.
interface leaf_hub_link_if #(
    parameter int unsigned CHANNEL_WIDTH = 64
);
    logic [CHANNEL_WIDTH-1:0] rx_din;
    logic                     rx_empty;
    logic                     rx_rd_en;
    logic [CHANNEL_WIDTH-1:0] tx_dout;
    logic                     tx_wr_en;
    logic                     tx_full;
    logic [CHANNEL_WIDTH-1:0] data_to_core;
    logic                     valid_to_core;
    logic                     ready_to_core;
    logic [CHANNEL_WIDTH-1:0] data_from_core;
    logic                     valid_from_core;
    logic                     ready_from_core;

    // master: the leaf endpoint; slave: link FIFOs plus local core
    modport master (
        input  rx_din, rx_empty, tx_full, ready_to_core, data_from_core, valid_from_core,
        output rx_rd_en, tx_dout, tx_wr_en, data_to_core, valid_to_core, ready_from_core
    );

    modport slave (
        output rx_din, rx_empty, tx_full, ready_to_core, data_from_core, valid_from_core,
        input  rx_rd_en, tx_dout, tx_wr_en, data_to_core, valid_to_core, ready_from_core
    );
endinterface

// File: rtl/link_tx_arbiter.sv
// One-entry tx register fed by pong replies (priority) or core words.
module link_tx_arbiter
    import link_pkg::*;
#(
    parameter int unsigned CHANNEL_WIDTH = LINK_CHANNEL_WIDTH,
    parameter int unsigned DEST_WIDTH    = LINK_DEST_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pong_req_i,
    input  logic [CHANNEL_WIDTH-1:0] pong_word_i,
    input  logic                     core_valid_i,
    input  logic [CHANNEL_WIDTH-1:0] core_word_i,
    input  logic                     tx_full_i,
    output logic                     pong_take_o,
    output logic                     core_ready_o,
    output logic                     tx_valid_o,
    output logic                     tx_wr_en_o,
    output logic [CHANNEL_WIDTH-1:0] tx_dout_o
);

    localparam logic [CHANNEL_WIDTH-1:0] DEST_CLEAR_MASK =
        {{DEST_WIDTH{1'b0}}, {(CHANNEL_WIDTH-DEST_WIDTH){1'b1}}};

    tx_state_e                state_q, state_d;
    logic [CHANNEL_WIDTH-1:0] data_q, data_d;
    logic                     drain;
    logic                     free;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= TX_IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        pong_take_o  = 1'b0;
        drain        = (state_q != TX_IDLE) && !tx_full_i;
        free         = (state_q == TX_IDLE) || drain;
        core_ready_o = !pong_req_i && free;

        // A draining register refills in the same cycle, so no bubble between words.
        if (free) begin
            if (pong_req_i) begin
                state_d     = TX_PONG;
                data_d      = pong_word_i;
                pong_take_o = 1'b1;
            end else if (core_valid_i) begin
                state_d = TX_CORE;
                data_d  = core_word_i & DEST_CLEAR_MASK;
            end else begin
                state_d = TX_IDLE;
            end
        end
    end

    assign tx_valid_o = (state_q != TX_IDLE);
    assign tx_wr_en_o = drain;
    assign tx_dout_o  = data_q;

endmodule

// File: rtl/leaf_hub_link.sv
// Child-side endpoint of the root-hub link: rx filter/deliver, ping auto-reply, tx merge.
module leaf_hub_link
    import link_pkg::*;
#(
    parameter int unsigned FPGA_ID        = 1,
    parameter int unsigned CHANNEL_WIDTH  = LINK_CHANNEL_WIDTH,
    parameter int unsigned DEST_WIDTH     = LINK_DEST_WIDTH,
    parameter int unsigned DROP_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    leaf_hub_link_if.master           lnk,
    output logic                      link_busy,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
);

    localparam int unsigned PAYLOAD_W   = CHANNEL_WIDTH - DEST_WIDTH - LINK_TYPE_WIDTH;
    localparam int unsigned PING_KEEP_W = PAYLOAD_W - DEST_WIDTH;

    logic [DEST_WIDTH-1:0]      head_dest;
    logic [LINK_TYPE_WIDTH-1:0] head_type;
    rx_class_e                  head_class;
    logic                       rx_pop;

    logic                       rx_valid_q, rx_valid_d;
    logic [CHANNEL_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                       ping_pending_q, ping_pending_d;
    logic [PING_KEEP_W-1:0]     ping_keep_q, ping_keep_d;
    logic [DROP_CNT_WIDTH-1:0]  drop_q, drop_d;

    logic                       pong_take;
    logic                       tx_valid;
    logic [CHANNEL_WIDTH-1:0]   pong_word;

    assign head_dest = lnk.rx_din[CHANNEL_WIDTH-1 -: DEST_WIDTH];
    assign head_type = lnk.rx_din[CHANNEL_WIDTH-DEST_WIDTH-1 -: LINK_TYPE_WIDTH];

    always_comb begin
        head_class = RX_DROP;
        if (head_dest == DEST_WIDTH'(FPGA_ID) || head_dest == BROADCAST[DEST_WIDTH-1:0])
            head_class = (head_type == MSG_PING) ? RX_PING : RX_DELIVER;
    end

    // Gated by reset so nothing is consumed from the FIFO while the block is held.
    always_comb begin
        rx_pop = 1'b0;
        if (!reset && !lnk.rx_empty) begin
            case (head_class)
                RX_DELIVER: rx_pop = !rx_valid_q || lnk.ready_to_core;
                RX_PING:    rx_pop = !ping_pending_q;
                default:    rx_pop = 1'b1;
            endcase
        end
    end

    always_comb begin
        rx_valid_d     = rx_valid_q;
        rx_data_d      = rx_data_q;
        ping_pending_d = ping_pending_q;
        ping_keep_d    = ping_keep_q;
        drop_d         = drop_q;

        if (rx_valid_q && lnk.ready_to_core)
            rx_valid_d = 1'b0;
        if (pong_take)
            ping_pending_d = 1'b0;

        if (rx_pop) begin
            case (head_class)
                RX_DELIVER: begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = lnk.rx_din;
                end
                RX_PING: begin
                    ping_pending_d = 1'b1;
                    ping_keep_d    = lnk.rx_din[PING_KEEP_W-1:0];
                end
                default: begin
                    if (drop_q != '1)
                        drop_d = drop_q + 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_valid_q     <= 1'b0;
            rx_data_q      <= '0;
            ping_pending_q <= 1'b0;
            ping_keep_q    <= '0;
            drop_q         <= '0;
        end else begin
            rx_valid_q     <= rx_valid_d;
            rx_data_q      <= rx_data_d;
            ping_pending_q <= ping_pending_d;
            ping_keep_q    <= ping_keep_d;
            drop_q         <= drop_d;
        end
    end

    assign pong_word = {{DEST_WIDTH{1'b0}}, MSG_PONG, ping_keep_q, DEST_WIDTH'(FPGA_ID)};

    link_tx_arbiter #(
        .CHANNEL_WIDTH (CHANNEL_WIDTH),
        .DEST_WIDTH    (DEST_WIDTH)
    ) u_tx_arbiter (
        .clk          (clk),
        .reset        (reset),
        .pong_req_i   (ping_pending_q),
        .pong_word_i  (pong_word),
        .core_valid_i (lnk.valid_from_core),
        .core_word_i  (lnk.data_from_core),
        .tx_full_i    (lnk.tx_full),
        .pong_take_o  (pong_take),
        .core_ready_o (lnk.ready_from_core),
        .tx_valid_o   (tx_valid),
        .tx_wr_en_o   (lnk.tx_wr_en),
        .tx_dout_o    (lnk.tx_dout)
    );

    assign lnk.rx_rd_en      = rx_pop;
    assign lnk.valid_to_core = rx_valid_q;
    assign lnk.data_to_core  = rx_data_q;
    assign link_busy         = ping_pending_q || rx_valid_q || tx_valid;
    assign drop_count        = drop_q;

endmodule

// File: tb/tb_leaf_hub_link.sv
// Directed latency checks plus randomized traffic against a queue-based reference model.
module tb_leaf_hub_link;
    import link_pkg::*;

    localparam int unsigned CW  = 64;
    localparam int unsigned ID  = 2;
    localparam int unsigned DCW = 4;

    logic clk = 1'b0;
    logic reset;
    logic link_busy;
    logic [DCW-1:0] drop_count;

    always #5 clk = ~clk;

    leaf_hub_link_if #(.CHANNEL_WIDTH(CW)) lnk ();

    leaf_hub_link #(
        .FPGA_ID        (ID),
        .CHANNEL_WIDTH  (CW),
        .DEST_WIDTH     (8),
        .DROP_CNT_WIDTH (DCW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .lnk        (lnk),
        .link_busy  (link_busy),
        .drop_count (drop_count)
    );

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [63:0] inq[$];
    logic [63:0] exp_rx[$];
    logic [63:0] exp_core[$];
    logic [63:0] exp_pong[$];
    int          ping_cyc[$];
    int unsigned model_drops;
    int          cyc_no;
    bit          chk_lat;
    bit          core_hold;
    logic [63:0] core_word;

    function automatic logic [63:0] mk(input logic [7:0] d, input logic [7:0] t, input logic [47:0] p);
        return {d, t, p};
    endfunction

    function automatic logic [63:0] pong_of(input logic [63:0] ping);
        return {8'h00, MSG_PONG, ping[39:0], 8'(ID)};
    endfunction

    function automatic logic [63:0] core_out(input logic [63:0] w);
        return {8'h00, w[55:0]};
    endfunction

    function automatic logic [DCW-1:0] sat(input int unsigned n);
        return (n >= (1 << DCW)) ? '1 : DCW'(n);
    endfunction

    function automatic logic [63:0] rand_word();
        logic [7:0] d;
        logic [7:0] t;
        case ($urandom_range(4))
            0: d = 8'(ID);
            1: d = 8'hFF;
            2: d = 8'h00;
            3: d = 8'h03;
            default: d = 8'($urandom);
        endcase
        t = ($urandom_range(3) == 0) ? MSG_PING : 8'($urandom);
        return mk(d, t, {16'($urandom), 32'($urandom)});
    endfunction

    task automatic idle_inputs();
        lnk.rx_empty        = 1'b1;
        lnk.rx_din          = '0;
        lnk.tx_full         = 1'b0;
        lnk.ready_to_core   = 1'b1;
        lnk.data_from_core  = '0;
        lnk.valid_from_core = 1'b0;
    endtask

    task automatic check_reset_state(input string pfx);
        check_eq({pfx, "_rx_rd_en"}, lnk.rx_rd_en, 1'b0);
        check_eq({pfx, "_tx_wr_en"}, lnk.tx_wr_en, 1'b0);
        check_eq({pfx, "_valid_to_core"}, lnk.valid_to_core, 1'b0);
        check_eq({pfx, "_data_to_core"}, lnk.data_to_core, 64'h0);
        check_eq({pfx, "_tx_dout"}, lnk.tx_dout, 64'h0);
        check_eq({pfx, "_ready_from_core"}, lnk.ready_from_core, 1'b1);
        check_eq({pfx, "_link_busy"}, link_busy, 1'b0);
        check_eq({pfx, "_drop_count"}, drop_count, 4'h0);
    endtask

    // One cycle of model-checked traffic; knobs are percentages.
    task automatic step(input int unsigned p_rx, input int unsigned p_rdy,
                        input int unsigned p_full, input int unsigned p_core);
        logic [63:0] w;
        @(negedge clk);
        if (inq.size() > 0 && $urandom_range(99) < p_rx) begin
            lnk.rx_empty = 1'b0;
            lnk.rx_din   = inq[0];
        end else begin
            lnk.rx_empty = 1'b1;
            lnk.rx_din   = '0;
        end
        lnk.ready_to_core = ($urandom_range(99) < p_rdy);
        lnk.tx_full       = ($urandom_range(99) < p_full);
        if (!core_hold && $urandom_range(99) < p_core) begin
            core_word        = {32'($urandom), 32'($urandom)};
            core_word[55:48] = 8'h40 | 8'($urandom_range(63));
            core_hold        = 1'b1;
        end
        lnk.valid_from_core = core_hold;
        lnk.data_from_core  = core_word;
        #1;
        check_eq("drop_count", drop_count, sat(model_drops));
        if (lnk.rx_rd_en) begin
            if (lnk.rx_empty || inq.size() == 0) begin
                check_eq("pop_while_empty", lnk.rx_empty, 1'b0);
            end else begin
                w = inq.pop_front();
                if (w[63:56] != 8'(ID) && w[63:56] != 8'hFF) begin
                    model_drops++;
                end else if (w[55:48] == MSG_PING) begin
                    exp_pong.push_back(pong_of(w));
                    ping_cyc.push_back(cyc_no);
                end else begin
                    exp_rx.push_back(w);
                end
            end
        end
        if (lnk.valid_to_core && lnk.ready_to_core) begin
            if (exp_rx.size() == 0) check_eq("rx_unexpected", 64'(exp_rx.size()), 64'd1);
            else check_eq("rx_data", lnk.data_to_core, exp_rx.pop_front());
        end
        if (lnk.tx_full) check_eq("wr_while_full", lnk.tx_wr_en, 1'b0);
        if (lnk.tx_wr_en) begin
            if (lnk.tx_dout[55:48] == MSG_PONG) begin
                if (exp_pong.size() == 0) begin
                    check_eq("pong_unexpected", 64'(exp_pong.size()), 64'd1);
                end else begin
                    check_eq("pong_word", lnk.tx_dout, exp_pong.pop_front());
                    if (chk_lat) check_eq("pong_latency", 64'(cyc_no - ping_cyc[0]), 64'd2);
                    void'(ping_cyc.pop_front());
                end
            end else begin
                if (exp_core.size() == 0) check_eq("core_unexpected", 64'(exp_core.size()), 64'd1);
                else check_eq("core_word", lnk.tx_dout, exp_core.pop_front());
            end
        end
        if (lnk.ready_from_core && lnk.valid_from_core) begin
            exp_core.push_back(core_out(core_word));
            core_hold = 1'b0;
        end
        cyc_no++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] w[4];
        logic [63:0] pw;
        logic [63:0] pb;
        logic [63:0] cw;
        int unsigned guard;

        reset = 1'b1;
        idle_inputs();
        lnk.rx_empty = 1'b0;
        lnk.rx_din   = mk(8'h03, 8'h10, 48'h1);
        repeat (2) @(negedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();

        // Back-to-back delivery
        for (int i = 0; i < 3; i++) w[i] = mk(8'(ID), 8'h10 + 8'(i), {16'($urandom), 32'($urandom)});
        @(negedge clk);
        lnk.rx_empty = 1'b0;
        lnk.rx_din   = w[0];
        #1;
        check_eq("deliver_pop0", lnk.rx_rd_en, 1'b1);
        check_eq("deliver_valid0", lnk.valid_to_core, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (i < 3) lnk.rx_din = w[i];
            else lnk.rx_empty = 1'b1;
            #1;
            check_eq("deliver_valid", lnk.valid_to_core, 1'b1);
            check_eq("deliver_data", lnk.data_to_core, w[i-1]);
        end
        @(negedge clk);
        #1;
        check_eq("deliver_done", lnk.valid_to_core, 1'b0);
        check_eq("deliver_drops", drop_count, 4'h0);

        // Wrong destination then broadcast
        pb = mk(8'hFF, 8'h11, 48'hBEEF_0000_CAFE);
        @(negedge clk);
        lnk.rx_empty = 1'b0;
        lnk.rx_din   = mk(8'h03, 8'h11, 48'h5);
        #1;
        check_eq("drop_pop", lnk.rx_rd_en, 1'b1);
        @(negedge clk);
        lnk.rx_din = pb;
        #1;
        check_eq("drop_count1", drop_count, 4'h1);
        check_eq("bcast_pop", lnk.rx_rd_en, 1'b1);
        check_eq("drop_not_delivered", lnk.valid_to_core, 1'b0);
        @(negedge clk);
        lnk.rx_empty = 1'b1;
        #1;
        check_eq("bcast_valid", lnk.valid_to_core, 1'b1);
        check_eq("bcast_data", lnk.data_to_core, pb);
        @(negedge clk);

        // Ping with payload 0x1234
        pw = mk(8'(ID), MSG_PING, 48'h1234);
        lnk.rx_empty = 1'b0;
        lnk.rx_din   = pw;
        #1;
        check_eq("ping_pop", lnk.rx_rd_en, 1'b1);
        check_eq("ping_wr0", lnk.tx_wr_en, 1'b0);
        @(negedge clk);
        lnk.rx_empty = 1'b1;
        #1;
        check_eq("ping_wr1", lnk.tx_wr_en, 1'b0);
        check_eq("ping_busy", link_busy, 1'b1);
        check_eq("ping_no_deliver", lnk.valid_to_core, 1'b0);
        check_eq("ping_blocks_core", lnk.ready_from_core, 1'b0);
        @(negedge clk);
        #1;
        check_eq("pong_wr", lnk.tx_wr_en, 1'b1);
        check_eq("pong_dout", lnk.tx_dout, 64'h0002_0000_0012_3402);
        @(negedge clk);
        #1;
        check_eq("pong_done", lnk.tx_wr_en, 1'b0);
        check_eq("pong_idle", link_busy, 1'b0);

        // Second ping stalls while the first is pending; word behind it keeps order
        w[0] = mk(8'(ID), MSG_PING, 48'hA1);
        w[1] = mk(8'(ID), MSG_PING, 48'hB2);
        w[2] = mk(8'(ID), 8'h22, 48'hD3);
        @(negedge clk);
        lnk.rx_empty = 1'b0;
        lnk.rx_din   = w[0];
        #1;
        check_eq("ping2_popA", lnk.rx_rd_en, 1'b1);
        @(negedge clk);
        lnk.rx_din = w[1];
        #1;
        check_eq("ping2_stallB", lnk.rx_rd_en, 1'b0);
        @(negedge clk);
        #1;
        check_eq("ping2_popB", lnk.rx_rd_en, 1'b1);
        check_eq("ping2_pongA_wr", lnk.tx_wr_en, 1'b1);
        check_eq("ping2_pongA", lnk.tx_dout, pong_of(w[0]));
        @(negedge clk);
        lnk.rx_din = w[2];
        #1;
        check_eq("ping2_popD", lnk.rx_rd_en, 1'b1);
        @(negedge clk);
        lnk.rx_empty = 1'b1;
        #1;
        check_eq("ping2_D_data", lnk.data_to_core, w[2]);
        check_eq("ping2_pongB_wr", lnk.tx_wr_en, 1'b1);
        check_eq("ping2_pongB", lnk.tx_dout, pong_of(w[1]));
        @(negedge clk);

        // tx_full holds the register
        cw = mk(8'h55, 8'h20, 48'h0123_4567_89AB);
        lnk.tx_full         = 1'b1;
        lnk.valid_from_core = 1'b1;
        lnk.data_from_core  = cw;
        #1;
        check_eq("full_accept", lnk.ready_from_core, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            lnk.data_from_core = mk(8'h66, 8'h21, 48'(k));
            #1;
            check_eq("full_wr", lnk.tx_wr_en, 1'b0);
            check_eq("full_dout", lnk.tx_dout, core_out(cw));
            check_eq("full_ready", lnk.ready_from_core, 1'b0);
        end
        @(negedge clk);
        lnk.tx_full         = 1'b0;
        lnk.valid_from_core = 1'b0;
        #1;
        check_eq("unfull_wr", lnk.tx_wr_en, 1'b1);
        check_eq("unfull_dout", lnk.tx_dout, core_out(cw));
        check_eq("unfull_ready", lnk.ready_from_core, 1'b1);
        @(negedge clk);
        #1;
        check_eq("unfull_done", lnk.tx_wr_en, 1'b0);

        // Core word latency
        cw = mk(8'h77, 8'h23, 48'hFEED_F00D_0042);
        @(negedge clk);
        lnk.valid_from_core = 1'b1;
        lnk.data_from_core  = cw;
        #1;
        check_eq("core_accept", lnk.ready_from_core, 1'b1);
        @(negedge clk);
        lnk.valid_from_core = 1'b0;
        #1;
        check_eq("core_lat_wr", lnk.tx_wr_en, 1'b1);
        check_eq("core_lat_dout", lnk.tx_dout, core_out(cw));

        // Drop counter saturation (already at 1)
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lnk.rx_empty = 1'b0;
            lnk.rx_din   = mk(8'h07, 8'h30, 48'(i));
            #1;
            check_eq("sat_pop", lnk.rx_rd_en, 1'b1);
        end
        @(negedge clk);
        lnk.rx_empty = 1'b1;
        #1;
        check_eq("sat_count", drop_count, 4'hF);

        // Reset mid-stream
        @(negedge clk);
        lnk.rx_empty        = 1'b0;
        lnk.rx_din          = mk(8'(ID), 8'h31, 48'h9);
        lnk.ready_to_core   = 1'b0;
        lnk.tx_full         = 1'b1;
        lnk.valid_from_core = 1'b1;
        lnk.data_from_core  = mk(8'h12, 8'h32, 48'h7);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("midrst");
        @(negedge clk);
        #1;
        check_eq("midrst_no_pop", lnk.rx_rd_en, 1'b0);
        check_eq("midrst_no_wr", lnk.tx_wr_en, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();

        // Core streaming while a ping arrives
        model_drops = 0;
        cyc_no      = 0;
        core_hold   = 1'b0;
        chk_lat     = 1'b1;
        inq.push_back(mk(8'(ID), MSG_PING, 48'h00AB_CDEF_0123));
        for (int i = 0; i < 12; i++) step((i == 4) ? 100 : 0, 100, 0, 100);
        for (int i = 0; i < 4; i++) step(0, 100, 0, 0);
        check_eq("stream_pong_left", 64'(exp_pong.size()), 64'd0);
        check_eq("stream_core_left", 64'(exp_core.size()), 64'd0);

        // Randomized traffic
        chk_lat = 1'b0;
        for (int i = 0; i < 400; i++) inq.push_back(rand_word());
        for (int i = 0; i < 1200; i++) step(70, 65, 30, 60);
        guard = 0;
        while ((inq.size() > 0 || exp_rx.size() > 0 || exp_core.size() > 0 ||
                exp_pong.size() > 0 || core_hold || link_busy) && guard < 2000) begin
            step(100, 100, 0, 0);
            guard++;
        end
        check_eq("left_inq", 64'(inq.size()), 64'd0);
        check_eq("left_rx", 64'(exp_rx.size()), 64'd0);
        check_eq("left_core", 64'(exp_core.size()), 64'd0);
        check_eq("left_pong", 64'(exp_pong.size()), 64'd0);
        check_eq("final_busy", link_busy, 1'b0);
        check_eq("final_drops", drop_count, sat(model_drops));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
